opsum_drain_arb: RTL and testbench

- Round-robin drain controller for NUM_FIFO opsum_fifo instances, one per PE column.
- Tracks each FIFO's occupancy by snooping pushes, then issues 16-bit or 32-bit pops (pop_mod).
- Forwards popped partial sums as single-beat word writes to the GLB write port, using per-FIFO address pointers.
- Sits between the PE-array opsum FIFOs and the GLB arbiter; the layer controller drives it via cfg_start / cfg_flush.

---
 rtl/opsum_drain_arb_pkg.sv | 19 +
 rtl/opsum_drain_arb_rr_arbiter.sv | 26 ++
 rtl/opsum_drain_arb.sv | 180 ++++++++++++++++++
 tb/tb_opsum_drain_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opsum_drain_arb_pkg.sv
// rtl/opsum_drain_arb_pkg.sv - shared types and constants for the opsum drain arbiter
package opsum_drain_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      POP,
      WAIT,
      WRITE
   } opsum_drain_state_e;

   localparam int OPSUM_W    = 16;
   localparam int GLB_DATA_W = 32;

   localparam logic [3:0] WEB_FULL = 4'b1111;
   localparam logic [3:0] WEB_LO   = 4'b0011;
   localparam logic [3:0] WEB_HI   = 4'b1100;

endpackage

// File: rtl/opsum_drain_arb_rr_arbiter.sv
// rtl/opsum_drain_arb_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module opsum_drain_arb_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            idx   = IW'((int'(ptr) + k) % N);
            gnt[(int'(ptr) + k) % N] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/opsum_drain_arb.sv
// rtl/opsum_drain_arb.sv - round-robin drain of PE-column opsum FIFOs into GLB word writes
module opsum_drain_arb
   import opsum_drain_arb_pkg::*;
#(
   parameter int NUM_FIFO   = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cfg_start,
   input  logic [NUM_FIFO*ADDR_W-1:0]     cfg_base_addr,
   input  logic                           cfg_flush,
   input  logic [NUM_FIFO-1:0]            fifo_push_en,
   input  logic [NUM_FIFO-1:0]            fifo_full,
   input  logic [NUM_FIFO-1:0]            fifo_empty,
   output logic [NUM_FIFO-1:0]            fifo_pop_en,
   output logic [NUM_FIFO-1:0]            fifo_pop_mod,
   input  logic [NUM_FIFO*GLB_DATA_W-1:0] fifo_pop_data,
   output logic                           glb_req,
   input  logic                           glb_gnt,
   output logic [ADDR_W-1:0]              glb_addr,
   output logic [GLB_DATA_W-1:0]          glb_wdata,
   output logic [3:0]                     glb_web,
   output logic                           busy,
   output logic                           done
);

   localparam int IW = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   opsum_drain_state_e    state_q, state_d;
   logic [CW-1:0]         cnt_q  [NUM_FIFO];
   logic [CW-1:0]         cnt_d  [NUM_FIFO];
   logic [CW:0]           cnt_up [NUM_FIFO];
   logic [CW:0]           cnt_dn [NUM_FIFO];
   logic [ADDR_W-1:0]     addr_q [NUM_FIFO];
   logic [ADDR_W-1:0]     addr_d [NUM_FIFO];
   logic [IW-1:0]         rr_q, rr_d, g_q, g_d;
   logic                  mod_q, mod_d, flush_q, flush_d;
   logic [GLB_DATA_W-1:0] data_q, data_d;

   logic [NUM_FIFO-1:0]   elig, arb_gnt;
   logic [IW-1:0]         arb_idx;
   logic                  arb_found;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_FIFO; i++) begin
         elig[i] = (!fifo_empty[i] && cnt_q[i] >= CW'(2)) || (flush_q && cnt_q[i] == CW'(1));
      end
   end

   opsum_drain_arb_rr_arbiter #(.N(NUM_FIFO), .IW(IW)) u_rr (
      .req   (elig),
      .ptr   (rr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .found (arb_found)
   );

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      g_d          = g_q;
      mod_d        = mod_q;
      flush_d      = flush_q;
      data_d       = data_q;
      fifo_pop_en  = '0;
      fifo_pop_mod = '0;
      glb_req      = 1'b0;
      done         = 1'b0;
      for (int i = 0; i < NUM_FIFO; i++) begin
         addr_d[i] = addr_q[i];
      end
      if (cfg_flush && state_q != IDLE) begin
         flush_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               for (int i = 0; i < NUM_FIFO; i++) begin
                  addr_d[i] = cfg_base_addr[i*ADDR_W +: ADDR_W];
               end
               state_d = ARB;
            end
         end
         ARB: begin
            if (arb_found) begin
               fifo_pop_en  = arb_gnt;
               fifo_pop_mod = (cnt_q[arb_idx] >= CW'(2)) ? arb_gnt : '0;
               g_d          = arb_idx;
               mod_d        = (cnt_q[arb_idx] >= CW'(2));
               state_d      = POP;
            end else if (flush_q) begin
               done    = 1'b1;
               flush_d = 1'b0;
               state_d = IDLE;
            end
         end
         POP: begin
            data_d  = fifo_pop_data[int'(g_q)*GLB_DATA_W +: GLB_DATA_W];
            state_d = WAIT;
         end
         WAIT: begin
            glb_req = 1'b1;
            if (glb_gnt) begin
               addr_d[g_q] = addr_q[g_q] + (mod_q ? ADDR_W'(4) : ADDR_W'(2));
               rr_d        = (int'(g_q) == NUM_FIFO - 1) ? '0 : g_q + 1'b1;
               state_d     = WRITE;
            end
         end
         WRITE: state_d = ARB;
         default: state_d = IDLE;
      endcase
   end

   // GLB outputs are forced to zero whenever no request is pending
   always_comb begin
      glb_addr  = '0;
      glb_wdata = '0;
      glb_web   = '0;
      if (glb_req) begin
         glb_addr = {addr_q[g_q][ADDR_W-1:2], 2'b00};
         if (mod_q) begin
            glb_wdata = data_q;
            glb_web   = WEB_FULL;
         end else if (addr_q[g_q][1]) begin
            glb_wdata = {data_q[OPSUM_W-1:0], {OPSUM_W{1'b0}}};
            glb_web   = WEB_HI;
         end else begin
            glb_wdata = {{OPSUM_W{1'b0}}, data_q[OPSUM_W-1:0]};
            glb_web   = WEB_LO;
         end
      end
   end

   assign busy = (state_q != IDLE);

   always_comb begin
      for (int i = 0; i < NUM_FIFO; i++) begin
         cnt_up[i] = {1'b0, cnt_q[i]} + {{CW{1'b0}}, (fifo_push_en[i] & ~fifo_full[i])};
         cnt_dn[i] = !fifo_pop_en[i] ? '0 : (fifo_pop_mod[i] ? (CW+1)'(2) : (CW+1)'(1));
         if (cnt_up[i] < cnt_dn[i]) begin
            cnt_d[i] = '0;
         end else if ((cnt_up[i] - cnt_dn[i]) > (CW+1)'(FIFO_DEPTH)) begin
            cnt_d[i] = CW'(FIFO_DEPTH);
         end else begin
            cnt_d[i] = CW'(cnt_up[i] - cnt_dn[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         g_q     <= '0;
         mod_q   <= 1'b0;
         flush_q <= 1'b0;
         data_q  <= '0;
         for (int i = 0; i < NUM_FIFO; i++) begin
            cnt_q[i]  <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         mod_q   <= mod_d;
         flush_q <= flush_d;
         data_q  <= data_d;
         for (int i = 0; i < NUM_FIFO; i++) begin
            cnt_q[i]  <= cnt_d[i];
            addr_q[i] <= addr_d[i];
         end
      end
   end

endmodule

// File: tb/tb_opsum_drain_arb.sv
// tb/tb_opsum_drain_arb.sv - scoreboard bench for opsum_drain_arb with behavioural opsum FIFOs
module tb_opsum_drain_arb;

   localparam int NF = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start, cfg_flush;
   logic [NF*32-1:0] cfg_base_addr;
   logic [NF-1:0] fifo_push_en, fifo_full, fifo_empty, fifo_pop_en, fifo_pop_mod;
   logic [NF*32-1:0] fifo_pop_data;
   logic          glb_req, glb_gnt;
   logic [31:0]   glb_addr, glb_wdata;
   logic [3:0]    glb_web;
   logic          busy, done;

   always #5 clk = ~clk;

   opsum_drain_arb dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start     (cfg_start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_flush     (cfg_flush),
      .fifo_push_en  (fifo_push_en),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .fifo_pop_en   (fifo_pop_en),
      .fifo_pop_mod  (fifo_pop_mod),
      .fifo_pop_data (fifo_pop_data),
      .glb_req       (glb_req),
      .glb_gnt       (glb_gnt),
      .glb_addr      (glb_addr),
      .glb_wdata     (glb_wdata),
      .glb_web       (glb_web),
      .busy          (busy),
      .done          (done)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  web;
   } wr_t;

   wr_t  sbq[$];
   int   nchk = 0, npass = 0;
   int   nwrites = 0, npops = 0, ndone = 0;

   logic [15:0] mem [NF][16];
   int          rp [NF];
   int          n  [NF];
   logic [15:0] pd [NF];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else npass++;
   endtask

   // Behavioural opsum FIFOs: registered pop data, 32-bit pop returns {second, first}
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NF; i++) begin
            rp[i] = 0;
            n[i]  = 0;
         end
         fifo_pop_data <= '0;
         fifo_empty    <= '1;
         fifo_full     <= '0;
      end else begin
         for (int i = 0; i < NF; i++) begin
            if (fifo_pop_en[i]) begin
               if (fifo_pop_mod[i]) begin
                  fifo_pop_data[i*32 +: 32] <= {mem[i][(rp[i]+1)%16], mem[i][rp[i]]};
                  rp[i] = (rp[i] + 2) % 16;
                  n[i]  = (n[i] >= 2) ? n[i] - 2 : 0;
               end else begin
                  fifo_pop_data[i*32 +: 32] <= {16'h0, mem[i][rp[i]]};
                  rp[i] = (rp[i] + 1) % 16;
                  n[i]  = (n[i] >= 1) ? n[i] - 1 : 0;
               end
            end
            if (fifo_push_en[i] && n[i] < 16) begin
               mem[i][(rp[i]+n[i])%16] = pd[i];
               n[i] = n[i] + 1;
            end
            fifo_empty[i] <= (n[i] == 0);
            fifo_full[i]  <= (n[i] == 16);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (fifo_pop_en != '0) begin
            npops++;
            check("pop_onehot", $countones(fifo_pop_en), 1);
            for (int i = 0; i < NF; i++)
               if (fifo_pop_en[i]) check("pop_mod", fifo_pop_mod, (n[i] >= 2) ? fifo_pop_en : 4'h0);
         end
         if (glb_req && glb_gnt) begin
            nwrites++;
            if (sbq.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               wr_t e;
               e = sbq.pop_front();
               check("glb_addr", glb_addr, e.addr);
               check("glb_wdata", glb_wdata, e.data);
               check("glb_web", glb_web, e.web);
            end
         end
         if (done) ndone++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cycle(input logic [3:0] mask, input logic [15:0] tag);
      for (int i = 0; i < NF; i++) pd[i] = tag | 16'(i);
      fifo_push_en = mask;
      step();
      fifo_push_en = '0;
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.web  = w;
      sbq.push_back(e);
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic drain(input string tag, input int max);
      for (int c = 0; c < max && sbq.size() != 0; c++) step();
      check(tag, sbq.size(), 0);
   endtask

   task automatic flush_and_wait(input string tag);
      int d0;
      d0 = ndone;
      cfg_flush = 1'b1;
      step();
      cfg_flush = 1'b0;
      for (int c = 0; c < 60 && ndone == d0; c++) step();
      check(tag, ndone - d0, 1);
      step();
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic wait_req(input string tag);
      for (int c = 0; c < 30 && !glb_req; c++) step();
      check(tag, glb_req, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a_s, d_s;
      logic [3:0]  w_s;
      int          w0, p0;

      rst_n         = 1'b0;
      cfg_start     = 1'b0;
      cfg_flush     = 1'b0;
      fifo_push_en  = '0;
      glb_gnt       = 1'b1;
      cfg_base_addr = {32'h400, 32'h300, 32'h200, 32'h100};
      for (int i = 0; i < NF; i++) pd[i] = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("rst_req", glb_req, 1'b0);
      check("rst_pop_en", fifo_pop_en, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_addr", glb_addr, 32'h0);
      check("rst_web", glb_web, 4'h0);

      // Session 1: all four FIFOs ready together, served 0..3, then pointer back at 0
      pulse_start();
      check("s1_busy", busy, 1'b1);
      for (int i = 0; i < NF; i++)
         expect_wr(32'h100 * (i + 1), {16'hB000 | 16'(i), 16'hA000 | 16'(i)}, 4'hF);
      push_cycle(4'hF, 16'hA000);
      push_cycle(4'hF, 16'hB000);
      drain("t2_rr_order", 80);
      expect_wr(32'h104, {16'hD000, 16'hC000}, 4'hF);
      expect_wr(32'h204, {16'hD001, 16'hC001}, 4'hF);
      push_cycle(4'h3, 16'hC000);
      push_cycle(4'h3, 16'hD000);
      drain("t2_rr_wrap", 40);
      flush_and_wait("s1_done");

      // Session 2: basic FIFO0 beat, then odd residue on FIFO1 only under flush
      pulse_start();
      expect_wr(32'h100, 32'h22221111, 4'hF);
      push_cycle(4'h1, 16'h1111);
      push_cycle(4'h1, 16'h2222);
      drain("t1_basic", 30);
      expect_wr(32'h200, {16'h4441, 16'h3331}, 4'hF);
      expect_wr(32'h204, {16'h0000, 16'h5551}, 4'h3);
      push_cycle(4'h2, 16'h3330);
      push_cycle(4'h2, 16'h4440);
      push_cycle(4'h2, 16'h5550);
      repeat (12) step();
      check("t3_no_half_before_flush", sbq.size(), 1);
      flush_and_wait("t3_done");
      check("t3_drained", sbq.size(), 0);

      // Session 3: GLB back-pressure, then push colliding with pop
      pulse_start();
      glb_gnt = 1'b0;
      expect_wr(32'h400, {16'h7773, 16'h6663}, 4'hF);
      push_cycle(4'h8, 16'h6660);
      push_cycle(4'h8, 16'h7770);
      wait_req("t4_req_seen");
      a_s = glb_addr;
      d_s = glb_wdata;
      w_s = glb_web;
      check("t4_addr_first", a_s, 32'h400);
      for (int c = 0; c < 5; c++) begin
         step();
         check("t4_req_hold", glb_req, 1'b1);
         check("t4_addr_hold", glb_addr, a_s);
         check("t4_wdata_hold", glb_wdata, d_s);
         check("t4_web_hold", glb_web, w_s);
         check("t4_no_pop", fifo_pop_en, 4'h0);
      end
      w0 = nwrites;
      glb_gnt = 1'b1;
      repeat (8) step();
      check("t4_one_transfer", nwrites - w0, 1);

      expect_wr(32'h300, {16'h9992, 16'h8882}, 4'hF);
      expect_wr(32'h304, {16'h0000, 16'hAAA2}, 4'h3);
      push_cycle(4'h4, 16'h8880);
      for (int i = 0; i < NF; i++) pd[i] = 16'h9990 | 16'(i);
      fifo_push_en = 4'h4;
      step();
      for (int i = 0; i < NF; i++) pd[i] = 16'hAAA0 | 16'(i);
      check("t5_pop_with_push", fifo_pop_en, 4'h4);
      step();
      fifo_push_en = '0;
      p0 = npops;
      repeat (20) step();
      check("t5_no_pop_cnt1", npops - p0, 0);
      check("t5_half_pending", sbq.size(), 1);
      flush_and_wait("t5_done");
      check("t5_drained", sbq.size(), 0);

      // Session 4: reset while a write waits for grant, then restart
      pulse_start();
      glb_gnt = 1'b0;
      push_cycle(4'h1, 16'hBBB0);
      push_cycle(4'h1, 16'hCCC0);
      wait_req("t6_req_seen");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_req", glb_req, 1'b0);
      check("t6_rst_addr", glb_addr, 32'h0);
      check("t6_rst_wdata", glb_wdata, 32'h0);
      check("t6_rst_web", glb_web, 4'h0);
      check("t6_rst_pop", fifo_pop_en, 4'h0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_done", done, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("t6_idle_after_rst", busy, 1'b0);
      glb_gnt = 1'b1;
      pulse_start();
      check("t6_restart_busy", busy, 1'b1);
      expect_wr(32'h400, {16'hEEE3, 16'hDDD3}, 4'hF);
      push_cycle(4'h8, 16'hDDD0);
      push_cycle(4'h8, 16'hEEE0);
      drain("t6_after_restart", 30);
      flush_and_wait("t6_done");

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
